// File: rtl/fp_pkg.sv
// Shared widths, flag positions and operand classes for the pipelined FP multiplier.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  localparam int FP_MAX_WIDTH = 64;

  function automatic int fpWidth(input int expWidth, input int fracWidth);
    return 1 + expWidth + fracWidth;
  endfunction

  function automatic int fpBias(input int expWidth);
    return (1 << (expWidth - 1)) - 1;
  endfunction

  function automatic int fpExpMax(input int expWidth);
    return (1 << expWidth) - 1;
  endfunction

  // Stage-1 bundle: {sign, result class, invalid, biased exponent sum, full product}.
  function automatic int s1Width(input int expWidth, input int fracWidth);
    return 4 + (expWidth + 2) + 2 * (fracWidth + 1);
  endfunction

  function automatic logic [FP_MAX_WIDTH-1:0] canonicalQnan(input int expWidth, input int fracWidth);
    logic [FP_MAX_WIDTH-1:0] one;
    logic [FP_MAX_WIDTH-1:0] q;
    one = {{(FP_MAX_WIDTH-1){1'b0}}, 1'b1};
    q = ((one << expWidth) - one) << fracWidth;
    q = q | (one << (fracWidth - 1));
    return q;
  endfunction

endpackage

// File: rtl/floating_point_multiplier_pipe_if.sv
// Operand/result bus with a shared valid/ready pair on each side.
interface floating_point_multiplier_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int LANES      = 1
);
  localparam int FPW = fpWidth(EXP_WIDTH, FRAC_WIDTH);

  logic [LANES*FPW-1:0] fp_a_i;
  logic [LANES*FPW-1:0] fp_b_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [LANES*FPW-1:0] fp_o;
  logic [LANES*4-1:0]   flags_o;
  logic                 valid_o;
  logic                 ready_i;

  modport slave (
    input  fp_a_i, fp_b_i, valid_i, ready_i,
    output ready_o, fp_o, flags_o, valid_o
  );

  modport master (
    output fp_a_i, fp_b_i, valid_i, ready_i,
    input  ready_o, fp_o, flags_o, valid_o
  );
endinterface

// File: rtl/floating_point_multiplier_lane.sv
// One multiplier lane: S1 classifies and multiplies, S2 normalises, rounds (RNE) and registers.
module floating_point_multiplier_lane
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  localparam int FPW = fpWidth(EXP_WIDTH, FRAC_WIDTH),
  localparam int S1W = s1Width(EXP_WIDTH, FRAC_WIDTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic [FPW-1:0] a_i,
  input  logic [FPW-1:0] b_i,
  input  logic           s0Valid_i,
  output logic [S1W-1:0] s1_o,
  input  logic [S1W-1:0] s2_i,
  input  logic           s2Valid_i,
  output logic [FPW-1:0] fp_o,
  output logic [3:0]     flags_o
);
  localparam int PW  = 2 * (FRAC_WIDTH + 1);
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] BIAS_S    = EW2'(fpBias(EXP_WIDTH));
  localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'(fpExpMax(EXP_WIDTH));
  localparam logic [FP_MAX_WIDTH-1:0] QNAN_WIDE = canonicalQnan(EXP_WIDTH, FRAC_WIDTH);
  localparam logic [FPW-1:0] QNAN = QNAN_WIDE[FPW-1:0];

  function automatic fp_class_t classify(input logic [EXP_WIDTH-1:0] e, input logic [FRAC_WIDTH-1:0] f);
    if (e == '0)      return ZERO;
    else if (e == '1) return (f == '0) ? INF : NAN;
    else              return NORMAL;
  endfunction

  logic [EXP_WIDTH-1:0]  expA, expB;
  logic [FRAC_WIDTH-1:0] fracA, fracB;
  fp_class_t             clsA, clsB, kind;
  logic                  invalid;
  logic signed [EW2-1:0] expSum;
  logic [PW-1:0]         mantA, mantB, prod;
  logic [S1W-1:0]        s1_d, s1_q;

  always_comb begin
    expA   = a_i[FPW-2 -: EXP_WIDTH];
    expB   = b_i[FPW-2 -: EXP_WIDTH];
    fracA  = a_i[FRAC_WIDTH-1:0];
    fracB  = b_i[FRAC_WIDTH-1:0];
    clsA   = classify(expA, fracA);
    clsB   = classify(expB, fracB);
    kind    = NORMAL;
    invalid = 1'b0;
    // Specials override arithmetic; a flushed subnormal simply behaves as zero here.
    if (clsA == NAN || clsB == NAN || (clsA == ZERO && clsB == INF) || (clsA == INF && clsB == ZERO)) begin
      kind    = NAN;
      invalid = (clsA == ZERO && clsB == INF) || (clsA == INF && clsB == ZERO) ||
                (clsA == NAN && !fracA[FRAC_WIDTH-1]) || (clsB == NAN && !fracB[FRAC_WIDTH-1]);
    end else if (clsA == INF || clsB == INF) begin
      kind = INF;
    end else if (clsA == ZERO || clsB == ZERO) begin
      kind = ZERO;
    end
    expSum = $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS_S;
    mantA  = {{(FRAC_WIDTH+1){1'b0}}, 1'b1, fracA};
    mantB  = {{(FRAC_WIDTH+1){1'b0}}, 1'b1, fracB};
    prod   = mantA * mantB;
    s1_d   = {a_i[FPW-1] ^ b_i[FPW-1], kind, invalid, expSum, prod};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                  s1_q <= '0;
    else if (en_i && s0Valid_i) s1_q <= s1_d;
  end

  assign s1_o = s1_q;

  logic                  sgn2, inv2;
  fp_class_t             kind2;
  logic signed [EW2-1:0] exp2, expNorm, expFinal;
  logic [PW-1:0]         prod2, normProd;
  logic [FRAC_WIDTH:0]   mant;
  logic [FRAC_WIDTH+1:0] mantRnd;
  logic [FRAC_WIDTH-1:0] fracRnd;
  logic                  guardBit, stickyBit, roundUp, carry, inexact;
  logic [FPW-1:0]        fp_d, fp_q;
  logic [3:0]            flags_d, flags_q;

  always_comb begin
    sgn2     = s2_i[S1W-1];
    kind2    = fp_class_t'(s2_i[S1W-2 -: 2]);
    inv2     = s2_i[S1W-4];
    exp2     = $signed(s2_i[PW +: EW2]);
    prod2    = s2_i[PW-1:0];
    normProd = prod2[PW-1] ? prod2 : {prod2[PW-2:0], 1'b0};
    expNorm  = exp2 + $signed({{(EW2-1){1'b0}}, prod2[PW-1]});
    mant      = normProd[PW-1 -: FRAC_WIDTH+1];
    guardBit  = normProd[FRAC_WIDTH];
    stickyBit = |normProd[FRAC_WIDTH-1:0];
    roundUp   = guardBit & (stickyBit | mant[0]);
    mantRnd   = {1'b0, mant} + {{(FRAC_WIDTH+1){1'b0}}, roundUp};
    // A carry out of rounding leaves 1.000..0, so the fraction is zero and the exponent bumps.
    carry     = mantRnd[FRAC_WIDTH+1];
    fracRnd   = carry ? '0 : mantRnd[FRAC_WIDTH-1:0];
    expFinal  = expNorm + $signed({{(EW2-1){1'b0}}, carry});
    inexact   = guardBit | stickyBit;
    fp_d    = '0;
    flags_d = '0;
    case (kind2)
      NAN: begin
        fp_d              = QNAN;
        flags_d[FLAG_INV] = inv2;
      end
      INF:  fp_d = {sgn2, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      ZERO: fp_d = {sgn2, {(FPW-1){1'b0}}};
      default: begin
        if (expFinal >= EXP_MAX_S) begin
          fp_d              = {sgn2, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
          flags_d[FLAG_OVF] = 1'b1;
          flags_d[FLAG_INX] = 1'b1;
        end else if (expFinal[EW2-1] || expFinal == '0) begin
          fp_d              = {sgn2, {(FPW-1){1'b0}}};
          flags_d[FLAG_UNF] = 1'b1;
          flags_d[FLAG_INX] = 1'b1;
        end else begin
          fp_d              = {sgn2, expFinal[EXP_WIDTH-1:0], fracRnd};
          flags_d[FLAG_INX] = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fp_q    <= '0;
      flags_q <= '0;
    end else if (en_i && s2Valid_i) begin
      fp_q    <= fp_d;
      flags_q <= flags_d;
    end
  end

  assign fp_o    = fp_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/floating_point_multiplier_pipe.sv
// Multi-lane pipelined FP multiplier; one global stall enable keeps every stage in lockstep.
module floating_point_multiplier_pipe
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH    = 8,
  parameter int FRAC_WIDTH   = 23,
  parameter int LANES        = 1,
  parameter int EXTRA_STAGES = 0
) (
  input logic clk_i,
  input logic rst_i,
  floating_point_multiplier_pipe_if.slave bus
);
  localparam int FPW = fpWidth(EXP_WIDTH, FRAC_WIDTH);
  localparam int S1W = s1Width(EXP_WIDTH, FRAC_WIDTH);
  localparam int VW  = EXTRA_STAGES + 2;

  logic                 en;
  logic [VW-1:0]        stageValid_q;
  logic                 outValid_q;
  logic [LANES*FPW-1:0] opA_q, opB_q;

  assign en          = !outValid_q || bus.ready_i;
  assign bus.ready_o = en && !rst_i;
  assign bus.valid_o = outValid_q;

  // stageValid_q[0] tracks S0, [1] tracks S1, higher bits track the retiming delays.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stageValid_q <= '0;
      outValid_q   <= 1'b0;
      opA_q        <= '0;
      opB_q        <= '0;
    end else if (en) begin
      stageValid_q <= {stageValid_q[VW-2:0], bus.valid_i};
      outValid_q   <= stageValid_q[VW-1];
      opA_q        <= bus.fp_a_i;
      opB_q        <= bus.fp_b_i;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [S1W-1:0] s1, s2In;
    logic [FPW-1:0] laneFp;
    logic [3:0]     laneFlags;

    floating_point_multiplier_lane #(
      .EXP_WIDTH  (EXP_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
    ) uLane (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en),
      .a_i       (opA_q[l*FPW +: FPW]),
      .b_i       (opB_q[l*FPW +: FPW]),
      .s0Valid_i (stageValid_q[0]),
      .s1_o      (s1),
      .s2_i      (s2In),
      .s2Valid_i (stageValid_q[VW-1]),
      .fp_o      (laneFp),
      .flags_o   (laneFlags)
    );

    if (EXTRA_STAGES > 0) begin : gDelay
      logic [S1W-1:0] delay_q [EXTRA_STAGES];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < EXTRA_STAGES; i++) delay_q[i] <= '0;
        end else if (en) begin
          delay_q[0] <= s1;
          for (int i = 1; i < EXTRA_STAGES; i++) delay_q[i] <= delay_q[i-1];
        end
      end
      assign s2In = delay_q[EXTRA_STAGES-1];
    end else begin : gNoDelay
      assign s2In = s1;
    end

    assign bus.fp_o[l*FPW +: FPW] = laneFp;
    assign bus.flags_o[l*4 +: 4]  = laneFlags;
  end

endmodule

// File: tb/tb_floating_point_multiplier_pipe.sv
// Scoreboard bench: a double-precision reference model predicts each accepted transaction.
module tb_floating_point_multiplier_pipe;
  import fp_pkg::*;

  localparam int EW = 8;
  localparam int FW = 23;
  localparam int LN = 2;
  localparam int XS = 1;

  typedef struct packed {
    logic [63:0] fp;
    logic [7:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  floating_point_multiplier_pipe_if #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .LANES(LN)) bus ();

  floating_point_multiplier_pipe #(
    .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .LANES(LN), .EXTRA_STAGES(XS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   stallLeft = 0;
  bit   randReady = 1'b0;

  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic [63:0] prevFp    = '0;
  logic [7:0]  prevFlags = '0;

  function automatic real toReal(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Product of two singles is exact in double; round that to single by the RNE rule.
  function automatic logic [35:0] refMul(input logic [31:0] a, input logic [31:0] b);
    bit za, zb, ia, ib, na, nb, g, st;
    logic s;
    logic [3:0] fl;
    logic [31:0] res;
    logic [63:0] d;
    logic [22:0] fr;
    real p;
    int e;
    za = (a[30:23] == 8'h00);
    zb = (b[30:23] == 8'h00);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    fl = '0;
    if (na || nb || (za && ib) || (ia && zb)) begin
      res = 32'h7FC00000;
      fl[FLAG_INV] = (za && ib) || (ia && zb) || (na && !a[22]) || (nb && !b[22]);
    end else if (ia || ib) begin
      res = {s, 8'hFF, 23'b0};
    end else if (za || zb) begin
      res = {s, 31'b0};
    end else begin
      p  = toReal(a) * toReal(b);
      d  = $realtobits(p);
      e  = int'(d[62:52]) - 1023 + 127;
      fr = d[51:29];
      g  = d[28];
      st = |d[27:0];
      if (g && (st || fr[0])) begin
        if (fr == '1) begin
          fr = '0;
          e  = e + 1;
        end else begin
          fr = fr + 1;
        end
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'b0};
        fl[FLAG_OVF] = 1'b1;
        fl[FLAG_INX] = 1'b1;
      end else if (e <= 0) begin
        res = {s, 31'b0};
        fl[FLAG_UNF] = 1'b1;
        fl[FLAG_INX] = 1'b1;
      end else begin
        res = {s, e[7:0], fr};
        fl[FLAG_INX] = g | st;
      end
    end
    return {fl, res};
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] r;
    logic [7:0]  e;
    logic [22:0] f;
    r = $urandom;
    f = r[22:0];
    case ($urandom_range(9))
      0:       e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(1) == 0) f = '0;
      end
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      4: begin
        e = 8'($urandom_range(110, 140));
        f = f & 23'h00000F;
      end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {r[31], e, f};
  endfunction

  task automatic checkEq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic driveCycle(input logic v, input logic [63:0] a, input logic [63:0] b, output bit accepted);
    exp_t e;
    logic [35:0] r;
    @(negedge clk);
    bus.valid_i = v;
    bus.fp_a_i  = a;
    bus.fp_b_i  = b;
    if (stallLeft > 0) begin
      bus.ready_i = 1'b0;
      stallLeft--;
    end else if (randReady) begin
      bus.ready_i = ($urandom_range(3) != 0);
    end else begin
      bus.ready_i = 1'b1;
    end
    #1;
    accepted = v && bus.ready_o;
    if (accepted) begin
      for (int l = 0; l < LN; l++) begin
        r = refMul(a[l*32 +: 32], b[l*32 +: 32]);
        e.fp[l*32 +: 32]  = r[31:0];
        e.flags[l*4 +: 4] = r[35:32];
      end
      sbq.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 100) begin
      driveCycle(1'b1, a, b, acc);
      tries++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL accept_timeout got=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) driveCycle(1'b0, '0, '0, acc);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [35:0] got, want;
    @(negedge clk);
    #2;
    if (rst) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
      return;
    end
    if (prevValid && !prevReady) begin
      checks++;
      if (!(bus.valid_o && bus.fp_o == prevFp && bus.flags_o == prevFlags)) begin
        errors++;
        $display("[TB] FAIL stall_hold got valid=%b fp=%h expected valid=1 fp=%h", bus.valid_o, bus.fp_o, prevFp);
      end
    end
    if (bus.valid_o && !bus.ready_i) begin
      checks++;
      if (bus.ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ready_stall got=%b expected=0", bus.ready_o);
      end
    end
    if (bus.valid_o && bus.ready_i) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output got fp=%h expected=no_output", bus.fp_o);
      end else begin
        e = sbq.pop_front();
        for (int l = 0; l < LN; l++) begin
          got  = {bus.flags_o[l*4 +: 4], bus.fp_o[l*32 +: 32]};
          want = {e.flags[l*4 +: 4], e.fp[l*32 +: 32]};
          checks++;
          if (got !== want) begin
            errors++;
            $display("[TB] FAIL lane%0d_result got fp=%h flags=%h expected fp=%h flags=%h",
                     l, got[31:0], got[35:32], want[31:0], want[35:32]);
          end
        end
      end
    end
    prevValid = bus.valid_o;
    prevReady = bus.ready_i;
    prevFp    = bus.fp_o;
    prevFlags = bus.flags_o;
  endtask

  initial forever checkOutput();

  initial begin
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL global_timeout got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    bit acc;
    int n;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.fp_a_i  = '0;
    bus.fp_b_i  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkEq("reset_ready_o", 64'(bus.ready_o), 64'd0);
    checkEq("reset_valid_o", 64'(bus.valid_o), 64'd0);
    checkEq("reset_fp_o", bus.fp_o, 64'd0);
    checkEq("reset_flags_o", 64'(bus.flags_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("ready_after_reset", 64'(bus.ready_o), 64'd1);

    $display("[TB] basic product and latency");
    applyStimulus({32'hC0000000, 32'h3FC00000}, {32'h3F000000, 32'h40000000});
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      driveCycle(1'b0, '0, '0, acc);
      lat++;
      if (bus.valid_o) break;
    end
    checkEq("latency", 64'(lat), 64'd4);
    idle(4);

    $display("[TB] directed corner cases");
    applyStimulus({32'h40400000, 32'h3F800001}, {32'h3F800000, 32'h3FC00000});
    applyStimulus({32'h7F800000, 32'h7F800000}, {32'hBF800000, 32'h00000000});
    applyStimulus({32'h00800000, 32'h7F7FFFFF}, {32'h3F000000, 32'h40000000});
    applyStimulus({32'hFFA00000, 32'h7F800001}, {32'h3F800000, 32'h00400000});
    idle(8);

    $display("[TB] backpressure stream");
    for (int k = 0; k < 8; k++) begin
      if (k == 4) stallLeft = 5;
      applyStimulus({1'b0, 8'($urandom_range(110, 140)), 23'($urandom), 1'b1, 8'($urandom_range(110, 140)), 23'($urandom)},
                    {1'b0, 8'($urandom_range(110, 140)), 23'($urandom), 1'b0, 8'($urandom_range(110, 140)), 23'($urandom)});
    end
    idle(12);

    $display("[TB] reset with results in flight");
    for (int k = 0; k < 3; k++)
      applyStimulus({randOp(), randOp()}, {randOp(), randOp()});
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    checkEq("ready_in_reset", 64'(bus.ready_o), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("valid_after_midreset", 64'(bus.valid_o), 64'd0);
    checkEq("ready_after_midreset", 64'(bus.ready_o), 64'd1);
    idle(8);

    $display("[TB] randomized traffic");
    randReady = 1'b1;
    repeat (300) applyStimulus({randOp(), randOp()}, {randOp(), randOp()});
    randReady = 1'b0;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      idle(1);
      n++;
    end
    checkEq("drain_queue_empty", 64'(sbq.size()), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
